// File: rtl/hazard_ctl_if.sv
// Decode-stage hazard bundle: decode/EX specifiers in, interlock controls out.
// The master drives the instruction info; hazard_ctl attaches as the slave.
interface hazard_ctl_if;
   logic       IdValid;
   logic [4:0] RSaddr;
   logic [4:0] RTaddr;
   logic       UsesRS;
   logic       UsesRT;
   logic       instIsSyscall;
   logic       MdStart;
   logic       MdRead;
   logic [4:0] ExRDaddr;
   logic       ExIsLoad;
   logic       Stall;
   logic       Bubble;
   logic       SyscallGo;
   logic       MdBusy;

   modport master (
      output IdValid, RSaddr, RTaddr, UsesRS, UsesRT, instIsSyscall,
             MdStart, MdRead, ExRDaddr, ExIsLoad,
      input  Stall, Bubble, SyscallGo, MdBusy
   );

   modport slave (
      input  IdValid, RSaddr, RTaddr, UsesRS, UsesRT, instIsSyscall,
             MdStart, MdRead, ExRDaddr, ExIsLoad,
      output Stall, Bubble, SyscallGo, MdBusy
   );
endinterface

// File: rtl/hazard_ctl.sv
// Decode-stage interlock controller: syscall drain sequencing, load-use
// interlock and MULT/DIV busy window, OR'd into a single stall/bubble.
module hazard_ctl #(
   parameter int SYS_WAIT = 2,
   parameter int MD_LAT   = 4
) (
   input  logic        MCLK,
   input  logic        MRST,
   hazard_ctl_if.slave hz
);
   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] SYS_DRAIN = 2'd1;
   localparam logic [1:0] SYS_GO    = 2'd2;
   localparam logic [1:0] SYS_REL   = 2'd3;

   localparam logic [2:0] SYS_LOAD = 3'(SYS_WAIT - 1);
   localparam logic [3:0] MD_LOAD  = 4'(MD_LAT);

   logic [1:0] state_reg, state_next;
   logic [2:0] sys_cnt_reg, sys_cnt_next;
   logic [3:0] md_cnt_reg, md_cnt_next;
   logic       syscall_hit, sys_term, load_use, md_busy, md_term, stall;

   always_comb begin
      syscall_hit = hz.IdValid & hz.instIsSyscall;
      load_use    = hz.IdValid & hz.ExIsLoad & (hz.ExRDaddr != 5'd0) &
                    ((hz.UsesRS & (hz.RSaddr == hz.ExRDaddr)) |
                     (hz.UsesRT & (hz.RTaddr == hz.ExRDaddr)));
      md_busy     = (md_cnt_reg != 4'd0);
      md_term     = hz.IdValid & (hz.MdRead | hz.MdStart) & md_busy;
      sys_term    = 1'b0;
      case (state_reg)
         IDLE:              sys_term = syscall_hit;
         SYS_DRAIN, SYS_GO: sys_term = 1'b1;
         default:           sys_term = 1'b0;  // SYS_REL lets the syscall advance
      endcase
      // Outputs must read 0 while reset is held, even with live inputs
      stall = MRST & (sys_term | load_use | md_term);
   end

   always_comb begin
      state_next   = state_reg;
      sys_cnt_next = sys_cnt_reg;
      case (state_reg)
         IDLE: begin
            if (syscall_hit) begin
               sys_cnt_next = SYS_LOAD;
               state_next   = (SYS_LOAD == 3'd0) ? SYS_GO : SYS_DRAIN;
            end
         end
         SYS_DRAIN: begin
            // GO lands exactly SYS_WAIT cycles after detection
            sys_cnt_next = sys_cnt_reg - 3'd1;
            if (sys_cnt_reg <= 3'd1) state_next = SYS_GO;
         end
         SYS_GO:  state_next = SYS_REL;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      md_cnt_next = md_cnt_reg;
      if (hz.IdValid & hz.MdStart & ~stall)
         md_cnt_next = MD_LOAD;
      else if (md_busy)
         md_cnt_next = md_cnt_reg - 4'd1;
   end

   always_ff @(posedge MCLK or negedge MRST) begin
      if (!MRST) begin
         state_reg   <= IDLE;
         sys_cnt_reg <= 3'd0;
         md_cnt_reg  <= 4'd0;
      end else begin
         state_reg   <= state_next;
         sys_cnt_reg <= sys_cnt_next;
         md_cnt_reg  <= md_cnt_next;
      end
   end

   assign hz.Stall     = stall;
   assign hz.Bubble    = stall;
   assign hz.SyscallGo = (state_reg == SYS_GO);
   assign hz.MdBusy    = md_busy;
endmodule

// File: tb/tb_hazard_ctl.sv
// Directed bench for hazard_ctl: cycle-age model checked every negedge plus
// hand-computed literal expectations for each scenario.
module tb_hazard_ctl;
   localparam int SYS_WAIT = 2;
   localparam int MD_LAT   = 4;

   logic MCLK = 1'b0;
   logic MRST = 1'b0;
   int   checks = 0;
   int   errors = 0;

   hazard_ctl_if hz();

   hazard_ctl #(.SYS_WAIT(SYS_WAIT), .MD_LAT(MD_LAT)) dut (
      .MCLK (MCLK),
      .MRST (MRST),
      .hz   (hz)
   );

   always #5 MCLK = ~MCLK;

   // Model: syscall tracked by age since detection, MD unit by ready cycle.
   int cyc_n    = 0;
   int sys_age  = -1;
   int md_ready = 0;
   bit m_st, m_go, m_busy;
   bit c_st, c_go, c_busy;

   function automatic void model_eval(output bit st, output bit go, output bit busy);
      bit sys_t, lu, mdt;
      busy  = MRST && (cyc_n < md_ready);
      sys_t = (sys_age < 0) ? (hz.IdValid && hz.instIsSyscall)
                            : (sys_age >= 1 && sys_age <= SYS_WAIT);
      lu    = hz.IdValid && hz.ExIsLoad && (hz.ExRDaddr != 0) &&
              ((hz.UsesRS && hz.RSaddr == hz.ExRDaddr) ||
               (hz.UsesRT && hz.RTaddr == hz.ExRDaddr));
      mdt   = hz.IdValid && (hz.MdRead || hz.MdStart) && busy;
      st    = MRST && (sys_t || lu || mdt);
      go    = MRST && (sys_age == SYS_WAIT);
   endfunction

   always @(posedge MCLK) cyc_n <= cyc_n + 1;

   always @(posedge MCLK or negedge MRST) begin
      if (!MRST) begin
         sys_age  <= -1;
         md_ready <= 0;
      end else begin
         model_eval(m_st, m_go, m_busy);
         if (sys_age >= 0)
            sys_age <= (sys_age == SYS_WAIT + 1) ? -1 : sys_age + 1;
         else if (hz.IdValid && hz.instIsSyscall)
            sys_age <= 1;
         if (hz.IdValid && hz.MdStart && !m_st)
            md_ready <= cyc_n + 1 + MD_LAT;
      end
   end

   always @(negedge MCLK) begin
      model_eval(c_st, c_go, c_busy);
      checks += 4;
      if (hz.Stall !== c_st) begin
         errors++;
         $display("FAIL cmp_stall cyc %0d: got %b expected %b", cyc_n, hz.Stall, c_st);
      end
      if (hz.Bubble !== c_st) begin
         errors++;
         $display("FAIL cmp_bubble cyc %0d: got %b expected %b", cyc_n, hz.Bubble, c_st);
      end
      if (hz.SyscallGo !== c_go) begin
         errors++;
         $display("FAIL cmp_syscallgo cyc %0d: got %b expected %b", cyc_n, hz.SyscallGo, c_go);
      end
      if (hz.MdBusy !== c_busy) begin
         errors++;
         $display("FAIL cmp_mdbusy cyc %0d: got %b expected %b", cyc_n, hz.MdBusy, c_busy);
      end
   end

   task automatic lit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end else begin
         $display("chk %s = %b", name, act);
      end
   endtask

   task automatic clr;
      hz.IdValid = 0; hz.RSaddr = 0; hz.RTaddr = 0; hz.UsesRS = 0; hz.UsesRT = 0;
      hz.instIsSyscall = 0; hz.MdStart = 0; hz.MdRead = 0;
      hz.ExRDaddr = 0; hz.ExIsLoad = 0;
   endtask

   task automatic tick;
      @(posedge MCLK);
      #1;
   endtask

   task automatic settle;
      #2;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      clr();
      repeat (2) @(posedge MCLK);
      #1;
      lit("reset stall", hz.Stall, 1'b0);
      lit("reset go", hz.SyscallGo, 1'b0);
      lit("reset busy", hz.MdBusy, 1'b0);
      MRST = 1'b1;
      tick();

      // Syscall held through the sequence, dropped once released
      for (int c = 0; c < 5; c++) begin
         clr();
         if (c < 4) begin hz.IdValid = 1; hz.instIsSyscall = 1; end
         settle();
         lit($sformatf("sys c%0d stall", c), hz.Stall, (c <= 2) ? 1'b1 : 1'b0);
         lit($sformatf("sys c%0d go", c), hz.SyscallGo, (c == 2) ? 1'b1 : 1'b0);
         tick();
      end

      // Load-use variants: match RT, load gone, r0, UsesRT off, RS match, no IdValid
      clr(); hz.IdValid = 1; hz.ExIsLoad = 1; hz.ExRDaddr = 5; hz.RTaddr = 5; hz.UsesRT = 1;
      settle(); lit("lu rt stall", hz.Stall, 1'b1); lit("lu rt bubble", hz.Bubble, 1'b1); tick();
      hz.ExIsLoad = 0;
      settle(); lit("lu gone stall", hz.Stall, 1'b0); tick();
      hz.ExIsLoad = 1; hz.ExRDaddr = 0; hz.RTaddr = 0;
      settle(); lit("lu r0 stall", hz.Stall, 1'b0); tick();
      hz.ExRDaddr = 5; hz.RTaddr = 5; hz.UsesRT = 0;
      settle(); lit("lu nouse stall", hz.Stall, 1'b0); tick();
      hz.RSaddr = 7; hz.UsesRS = 1; hz.ExRDaddr = 7;
      settle(); lit("lu rs stall", hz.Stall, 1'b1); tick();
      hz.IdValid = 0;
      settle(); lit("lu invalid stall", hz.Stall, 1'b0); tick();

      // MULT at c0, MFLO from c1 waits through the busy window
      for (int c = 0; c < 6; c++) begin
         clr(); hz.IdValid = 1;
         if (c == 0) hz.MdStart = 1; else hz.MdRead = 1;
         settle();
         lit($sformatf("md c%0d busy", c), hz.MdBusy, (c >= 1 && c <= 4) ? 1'b1 : 1'b0);
         lit($sformatf("md c%0d stall", c), hz.Stall, (c >= 1 && c <= 4) ? 1'b1 : 1'b0);
         tick();
      end

      // Back-to-back DIV: second start at c2 waits until c5, then reloads
      for (int c = 0; c < 11; c++) begin
         clr();
         if (c == 0 || (c >= 2 && c <= 5)) begin hz.IdValid = 1; hz.MdStart = 1; end
         settle();
         lit($sformatf("div c%0d busy", c), hz.MdBusy,
             ((c >= 1 && c <= 4) || (c >= 6 && c <= 9)) ? 1'b1 : 1'b0);
         lit($sformatf("div c%0d stall", c), hz.Stall, (c >= 2 && c <= 4) ? 1'b1 : 1'b0);
         tick();
      end

      // Syscall detected alongside a load-use hazard
      for (int c = 0; c < 5; c++) begin
         clr();
         if (c < 4) begin hz.IdValid = 1; hz.instIsSyscall = 1; end
         if (c == 0) begin hz.ExIsLoad = 1; hz.ExRDaddr = 3; hz.RSaddr = 3; hz.UsesRS = 1; end
         settle();
         lit($sformatf("ovl c%0d stall", c), hz.Stall, (c <= 2) ? 1'b1 : 1'b0);
         lit($sformatf("ovl c%0d go", c), hz.SyscallGo, (c == 2) ? 1'b1 : 1'b0);
         tick();
      end

      // Reset mid-drain with the MD unit busy
      clr(); hz.IdValid = 1; hz.MdStart = 1;
      settle(); tick();
      clr(); hz.IdValid = 1; hz.instIsSyscall = 1;
      settle(); lit("rst pre busy", hz.MdBusy, 1'b1); lit("rst pre stall", hz.Stall, 1'b1); tick();
      MRST = 1'b0;
      #1;
      lit("rst async stall", hz.Stall, 1'b0);
      lit("rst async bubble", hz.Bubble, 1'b0);
      lit("rst async go", hz.SyscallGo, 1'b0);
      lit("rst async busy", hz.MdBusy, 1'b0);
      tick();
      clr(); MRST = 1'b1;
      for (int c = 0; c < 5; c++) begin
         settle();
         lit($sformatf("rst post c%0d go", c), hz.SyscallGo, 1'b0);
         lit($sformatf("rst post c%0d busy", c), hz.MdBusy, 1'b0);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
